alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the processor datapath. It replaces the purely combinational 8-bit ALU with a WIDTH-bit unit that:
- keeps the existing 5-bit opcode map;
- adds sequential multiply, divide and modulo, plus arithmetic shift right;
- corrects LSR to a logical right shift;
- returns registered Z/N/C/V flags through a valid/ready handshake, so the control FSM can stall on long operations.

## Interface
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), width of the meaningful shift-amount field.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- operation  in  5  opcode.
- is_signed  in  1  sign-extend op1 for the ADD/SUB class (overflow semantics); ignored elsewhere.
- op1, op2  in  WIDTH  operands.
- out_valid  out  1  result/flags valid, held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flag_z, flag_n, flag_c, flag_v  out  1  registered flags.
- div_zero  out  1  the last DIV/MOD had op2 == 0.

## Operation
- Opcodes:
  - 0 NOP → 0.
  - 1 B, 2 BEQ, 3 ADD, 5 LOAD, 6 STR, 7 ADDI, 9 BL → op1+op2.
  - 4 SUB, 16 CMP → op1−op2.
  - 10 AND, 12 ANDI → AND.
  - 11 ORR, 13 ORRI → OR.
  - 14 LSL → op1 << op2.
  - 15 LSR → logical op1 >> op2.
  - 17 ASR → arithmetic op1 >>> op2.
  - 18 MUL → low WIDTH bits of op1*op2 (unsigned).
  - 19 DIV → unsigned quotient.
  - 20 MOD → unsigned remainder.
  - 8 BX and all undefined opcodes → 0.
- Shifts:
  - If op2 ≥ WIDTH, LSL/LSR give 0 and ASR gives all copies of op1[WIDTH-1].
  - Otherwise the shift amount is op2[SHW-1:0].
- Flags:
  - Z = (result == 0); N = result[WIDTH-1].
  - Add class: C = carry out of bit WIDTH-1; V = signed overflow (both operands same sign, result sign differs).
  - SUB/CMP: C = 1 when op1 ≥ op2 unsigned (no borrow); V = signed overflow of the subtraction.
  - All other ops: C = 0, V = 0.
  - V is computed identically whether is_signed is 0 or 1.
- MUL is shift-add, one multiplier bit per cycle, WIDTH iterations. A 2·WIDTH-bit accumulator is used internally; only the low half is output.
- DIV/MOD is restoring division, one quotient bit per cycle, WIDTH iterations.
- Division by zero:
  - Completes with the same latency.
  - DIV gives all ones; MOD gives op1.
  - div_zero = 1.
- div_zero is cleared by any accepted non-DIV/MOD operation.
- FSM states:
  - IDLE: in_ready = 1.
    - Accepting a single-cycle op → DONE, with the result registered at the accept edge.
    - Accepting MUL/DIV/MOD → ITER, with operands latched and the iteration counter set to 0.
  - ITER: count 0..WIDTH-1. When count == WIDTH-1 the final step is written to result/flags → DONE.
  - DONE: out_valid = 1.
    - If out_ready = 0, stay in DONE.
    - If out_ready = 1 and in_valid = 0 → IDLE.
    - If out_ready = 1 and in_valid = 1, the new request is accepted in the same cycle. in_ready = out_ready in DONE. Next state is per the IDLE rules (DONE again, or ITER).
- Requests are ignored in ITER (in_ready = 0). Only one operation is in flight.
- result, flags and div_zero change only on completion; they are stable while out_valid = 1.

## Timing
- Reset, asynchronous and immediate:
  - State = IDLE.
  - result = 0; all flags = 0; div_zero = 0.
  - out_valid = 0; in_ready = 1 from the first cycle after release.
- Reset asserted during ITER or DONE aborts the operation and discards the result.
- Single-cycle op accepted at edge t → out_valid = 1 in the cycle after t.
- MUL/DIV/MOD accepted at edge t → out_valid = 1 after edge t+WIDTH (latency WIDTH+1 cycles).
- Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.
- in_ready is combinational from state and out_ready only. No combinational path from op1/op2/operation to any output.

## Test plan
- **Reset:** assert rst_n = 0 mid-MUL → all outputs 0 immediately. After release: in_ready = 1, out_valid = 0.
- **ADD, WIDTH = 8:**
  - 0x7F + 0x01 → 0x80; N = 1, V = 1, C = 0.
  - 0xFF + 0x01 → 0x00; Z = 1, C = 1, V = 0.
  - out_valid appears 1 cycle after accept.
- **CMP / shifts:**
  - CMP 5,5 → Z = 1, C = 1.
  - CMP 3,5 → 0xFE; N = 1, C = 0.
  - LSR 0x80 by 3 → 0x10.
  - ASR 0x80 by 3 → 0xF0.
  - LSL 0x01 by 9 → 0x00.
- **MUL:**
  - 13*11 → 143 (0x8F); out_valid exactly 9 cycles after accept; in_ready = 0 throughout ITER.
  - 0xFF*0xFF → 0x01.
- **DIV/MOD:**
  - DIV 200,7 → 28; MOD 200,7 → 4.
  - DIV 9,0 → 0xFF with div_zero = 1; MOD 9,0 → 9.
  - A following ADD clears div_zero.
- **Backpressure / back-to-back:**
  - Hold out_ready = 0 for 5 cycles → result stable, no new accept.
  - Then out_ready = 1 with in_valid = 1 → next op accepted in that same cycle.
  - A stream of 4 ADDs completes in 4 consecutive cycles.
  - Rerun the whole plan with WIDTH = 16 and confirm MUL latency = 17.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus sequential
// shift-add multiply and restoring divide/modulo. Results and Z/N/C/V flags
// are registered and returned through a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request, in_ready = 1
// ITER  | MUL/DIV/MOD in progress, one bit per cycle, requests ignored
// DONE  | result/flags valid, held until out_ready; may accept next op
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       operation,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div_zero
);

  localparam logic [4:0] OP_B    = 5'd1;
  localparam logic [4:0] OP_BEQ  = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_LOAD = 5'd5;
  localparam logic [4:0] OP_STR  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_BL   = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_ORR  = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORRI = 5'd13;
  localparam logic [4:0] OP_LSL  = 5'd14;
  localparam logic [4:0] OP_LSR  = 5'd15;
  localparam logic [4:0] OP_CMP  = 5'd16;
  localparam logic [4:0] OP_ASR  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_DIV  = 5'd19;
  localparam logic [4:0] OP_MOD  = 5'd20;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [1:0] K_MUL = 2'd0;
  localparam logic [1:0] K_DIV = 2'd1;
  localparam logic [1:0] K_MOD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [1:0]       kind;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             accept;
  logic             is_iter_op;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic             shift_big;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] iter_res;
  logic             opb_zero;

  // is_signed has no effect on result or flags: the signed-overflow V is
  // the same whether op1 is treated as sign- or zero-extended.
  logic unused_is_signed;
  assign unused_is_signed = is_signed;

  assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign is_iter_op = (operation == OP_MUL) || (operation == OP_DIV) ||
                      (operation == OP_MOD);

  assign add_full  = {1'b0, op1} + {1'b0, op2};
  assign sub_full  = {1'b0, op1} - {1'b0, op2};
  assign shamt     = op2[SHW-1:0];
  assign shift_big = (op2 >= WIDTH_V);

  // Single-cycle datapath: result and carry/overflow for every non-iterative op.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (operation)
      OP_B, OP_BEQ, OP_ADD, OP_LOAD, OP_STR, OP_ADDI, OP_BL: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (op1[MSB] == op2[MSB]) && (add_full[MSB] != op1[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = ~sub_full[WIDTH];
        sc_v   = (op1[MSB] != op2[MSB]) && (sub_full[MSB] != op1[MSB]);
      end
      OP_AND, OP_ANDI: sc_res = op1 & op2;
      OP_ORR, OP_ORRI: sc_res = op1 | op2;
      OP_LSL: sc_res = shift_big ? '0 : (op1 << shamt);
      OP_LSR: sc_res = shift_big ? '0 : (op1 >> shamt);
      OP_ASR: sc_res = shift_big ? {WIDTH{op1[MSB]}}
                                 : $unsigned($signed(op1) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  assign opb_zero = (opb == '0);
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
  assign rem_sh   = {acc_hi, acc_lo[MSB]};
  assign div_ge   = (rem_sh >= {1'b0, opb});
  // When div_ge holds the true difference is below opb, so WIDTH bits suffice.
  assign div_diff = rem_sh[WIDTH-1:0] - opb;

  // One iteration step: MUL shifts {acc_hi,acc_lo} right after a conditional
  // add; DIV/MOD shifts the remainder left and conditionally subtracts.
  always_comb begin
    hi_next = '0;
    lo_next = '0;
    if (kind == K_MUL) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[MSB:1]};
    end else begin
      hi_next = div_ge ? div_diff : rem_sh[WIDTH-1:0];
      lo_next = {acc_lo[MSB-1:0], div_ge};
    end
  end

  // Final value written back when the last iteration completes.
  always_comb begin
    iter_res = lo_next;
    if (kind == K_DIV && opb_zero) begin
      iter_res = '1;
    end else if (kind == K_MOD) begin
      iter_res = opb_zero ? opa : hi_next;
    end
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      kind      <= K_MUL;
      opa       <= '0;
      opb       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_iter_op) begin
              state     <= S_ITER;
              out_valid <= 1'b0;
              cnt       <= '0;
              opa       <= op1;
              opb       <= op2;
              acc_hi    <= '0;
              if (operation == OP_MUL) begin
                kind   <= K_MUL;
                acc_lo <= op2;
              end else begin
                kind   <= (operation == OP_DIV) ? K_DIV : K_MOD;
                acc_lo <= op1;
              end
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= sc_res;
              flag_z    <= (sc_res == '0);
              flag_n    <= sc_res[MSB];
              flag_c    <= sc_c;
              flag_v    <= sc_v;
              div_zero  <= 1'b0;
            end
          end else if (state == S_DONE && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_ITER: begin
          acc_hi <= hi_next;
          acc_lo <= lo_next;
          cnt    <= cnt + SHW'(1);
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= iter_res;
            flag_z    <= (iter_res == '0);
            flag_n    <= iter_res[MSB];
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            div_zero  <= (kind != K_MUL) && opb_zero;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: an 8-bit and a 16-bit instance, a behavioural reference
// model feeding per-instance scoreboards, plus directed latency, backpressure,
// throughput and reset checks.
module tb_alu_mc;

  localparam logic [4:0] NOP = 5'd0,  B    = 5'd1,  ADD  = 5'd3,  SUB  = 5'd4;
  localparam logic [4:0] AND_ = 5'd10, ORR = 5'd11, LSL  = 5'd14, LSR  = 5'd15;
  localparam logic [4:0] CMP = 5'd16, ASR  = 5'd17, MUL  = 5'd18, DIV  = 5'd19;
  localparam logic [4:0] MOD = 5'd20;

  typedef struct packed {
    logic        dz;
    logic        v;
    logic        c;
    logic        n;
    logic        z;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, h_in_valid;
  logic [4:0]  operation;
  logic        is_signed;
  logic [15:0] op1, op2;
  logic        out_ready;

  logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, div_zero;
  logic [7:0]  result;
  logic        h_in_ready, h_out_valid, h_flag_z, h_flag_n, h_flag_c, h_flag_v;
  logic        h_div_zero;
  logic [15:0] h_result;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pops8 = 0;
  exp_t sb8[$];
  exp_t sb16[$];
  exp_t got8, got16, want8, want16;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .is_signed(is_signed), .op1(op1[7:0]), .op2(op2[7:0]),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .div_zero(div_zero)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .operation(operation), .is_signed(is_signed), .op1(op1), .op2(op2),
    .out_valid(h_out_valid), .out_ready(out_ready), .result(h_result),
    .flag_z(h_flag_z), .flag_n(h_flag_n), .flag_c(h_flag_c), .flag_v(h_flag_v),
    .div_zero(h_div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour using native arithmetic on a w-bit value.
  function automatic exp_t model(int w, logic [4:0] op, logic [15:0] a_in,
                                 logic [15:0] b_in);
    longint unsigned mask, a, b, r, s;
    logic ms_a, ms_b;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    a = {48'd0, a_in} & mask;
    b = {48'd0, b_in} & mask;
    ms_a = a[w-1];
    ms_b = b[w-1];
    e = '0;
    r = 0;
    case (op)
      5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd7, 5'd9: begin
        s = a + b;
        r = s & mask;
        e.c = s[w];
        e.v = (ms_a == ms_b) && (r[w-1] != ms_a);
      end
      5'd4, 5'd16: begin
        r = (a - b) & mask;
        e.c = (a >= b);
        e.v = (ms_a != ms_b) && (r[w-1] != ms_a);
      end
      5'd10, 5'd12: r = a & b;
      5'd11, 5'd13: r = a | b;
      5'd14: r = (b >= 64'(w)) ? 0 : ((a << b) & mask);
      5'd15: r = (b >= 64'(w)) ? 0 : (a >> b);
      5'd17: begin
        if (b >= 64'(w)) r = ms_a ? mask : 0;
        else begin
          r = a >> b;
          if (ms_a) r = r | (mask & ~(mask >> b));
        end
      end
      5'd18: r = (a * b) & mask;
      5'd19: begin r = (b == 0) ? mask : a / b; e.dz = (b == 0); end
      5'd20: begin r = (b == 0) ? a : a % b; e.dz = (b == 0); end
      default: r = 0;
    endcase
    e.res = r[31:0];
    e.z = (r == 0);
    e.n = r[w-1];
    return e;
  endfunction

  // Scoreboards: compare on output handshake, then record on input handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got8 = '0;
      got8.res = {24'd0, result};
      {got8.dz, got8.v, got8.c, got8.n, got8.z} = {div_zero, flag_v, flag_c, flag_n, flag_z};
      if (sb8.size() == 0) check_val("sb8_underflow", 1, 0);
      else begin
        want8 = sb8.pop_front();
        check_val("sb8_result_flags", got8, want8);
      end
      pops8 <= pops8 + 1;
    end
    if (in_valid && in_ready) sb8.push_back(model(8, operation, op1, op2));
  end

  always @(negedge clk) begin
    if (h_out_valid && out_ready) begin
      got16 = '0;
      got16.res = {16'd0, h_result};
      {got16.dz, got16.v, got16.c, got16.n, got16.z} =
        {h_div_zero, h_flag_v, h_flag_c, h_flag_n, h_flag_z};
      if (sb16.size() == 0) check_val("sb16_underflow", 1, 0);
      else begin
        want16 = sb16.pop_front();
        check_val("sb16_result_flags", got16, want16);
      end
    end
    if (h_in_valid && h_in_ready) sb16.push_back(model(16, operation, op1, op2));
  end

  function automatic logic rdy(int w);
    return (w == 16) ? h_in_ready : in_ready;
  endfunction

  function automatic logic vld(int w);
    return (w == 16) ? h_out_valid : out_valid;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(int w, logic [4:0] op, logic [15:0] a, logic [15:0] b);
    int n = 0;
    operation = op;
    op1 = a;
    op2 = b;
    is_signed = 1'($urandom_range(0, 1));
    if (w == 16) h_in_valid = 1'b1;
    else in_valid = 1'b1;
    @(negedge clk);
    while (!rdy(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("issue_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    h_in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid: 0 for single-cycle ops,
  // WIDTH for MUL/DIV/MOD (WIDTH+1 cycles including the accept cycle).
  task automatic lat(int w, logic [4:0] op, logic [15:0] a, logic [15:0] b,
                     int exp_lat, string tag);
    int n = 0;
    int rdy_hi = 0;
    issue(w, op, a, b);
    @(negedge clk);
    while (!vld(w) && n < 200) begin
      if (rdy(w)) rdy_hi++;
      @(negedge clk);
      n++;
    end
    check_val(tag, n, exp_lat);
    check_val({tag, "_in_ready_low"}, rdy_hi, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int c0, p0;
    logic [7:0] hold;
    logic [4:0] rop;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    in_valid = 1'b0;
    h_in_valid = 1'b0;
    operation = NOP;
    is_signed = 1'b0;
    op1 = '0;
    op2 = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {result, flag_z, flag_n, flag_c, flag_v, div_zero, out_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_in_ready", in_ready, 1);
    check_val("post_reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    lat(8, ADD, 16'h7F, 16'h01, 0, "add_7f_lat");
    lat(8, ADD, 16'hFF, 16'h01, 0, "add_ff_lat");
    check_val("add_ff_zc", {result, flag_z, flag_c, flag_v}, {8'h00, 3'b110});
    lat(8, CMP, 16'd5, 16'd5, 0, "cmp_55");
    lat(8, CMP, 16'd3, 16'd5, 0, "cmp_35");
    check_val("cmp_35_res_n_c", {result, flag_n, flag_c}, {8'hFE, 2'b10});
    issue(8, LSR, 16'h80, 16'd3);
    issue(8, ASR, 16'h80, 16'd3);
    issue(8, LSL, 16'h01, 16'd9);
    issue(8, ASR, 16'h80, 16'd9);
    issue(8, LSR, 16'h80, 16'd8);
    issue(8, LSL, 16'h01, 16'd7);
    issue(8, SUB, 16'h80, 16'h01);

    lat(8, MUL, 16'd13, 16'd11, 8, "mul_lat8");
    check_val("mul_13x11", result, 8'h8F);
    lat(8, MUL, 16'hFF, 16'hFF, 8, "mul_ff_lat8");
    lat(8, DIV, 16'd200, 16'd7, 8, "div_lat8");
    check_val("div_200_7", result, 8'd28);
    lat(8, MOD, 16'd200, 16'd7, 8, "mod_lat8");
    lat(8, DIV, 16'd9, 16'd0, 8, "div0_lat8");
    check_val("div0_res_dz", {result, div_zero}, {8'hFF, 1'b1});
    lat(8, MOD, 16'd9, 16'd0, 8, "mod0_lat8");
    lat(8, ADD, 16'd1, 16'd2, 0, "add_after_div0");
    check_val("div_zero_cleared", div_zero, 0);

    // Backpressure: result held, pending request not taken until out_ready.
    out_ready = 1'b0;
    issue(8, ADD, 16'h12, 16'h34);
    in_valid = 1'b1;
    operation = SUB;
    op1 = 16'h10;
    op2 = 16'h20;
    hold = 8'h46;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (result !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check_val("bp_hold", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_same_cycle_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("bp_next_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Four back-to-back ADDs: one accept and one result per cycle.
    c0 = cyc;
    p0 = pops8;
    for (int i = 0; i < 4; i++) issue(8, ADD, 16'(i * 40 + 3), 16'(i + 1));
    check_val("stream_accept_cycles", cyc - c0, 4);
    @(negedge clk);
    #1;
    check_val("stream_results", pops8 - p0, 4);
    @(posedge clk);
    #1;

    // Reset in the middle of a MUL discards it and clears outputs at once.
    issue(8, MUL, 16'd13, 16'd11);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_mul_outputs",
              {result, flag_z, flag_n, flag_c, flag_v, div_zero, out_valid}, 0);
    check_val("rst_mid_mul_pending", sb8.size(), 1);
    sb8.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_release_in_ready", in_ready, 1);
    check_val("rst_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rop == LSL || rop == LSR || rop == ASR) rb = 16'($urandom_range(0, 10));
      if ((rop == DIV || rop == MOD) && (i % 5 == 0)) rb = 16'd0;
      issue(8, rop, ra, rb);
    end
    repeat (20) @(posedge clk);
    #1;
    check_val("sb8_drained", sb8.size(), 0);

    // 16-bit instance: same plan at the wider width.
    lat(16, ADD, 16'h7FFF, 16'h0001, 0, "w16_add_lat");
    lat(16, ADD, 16'hFFFF, 16'h0001, 0, "w16_add_carry");
    issue(16, CMP, 16'd3, 16'd5);
    issue(16, LSR, 16'h8000, 16'd3);
    issue(16, ASR, 16'h8000, 16'd3);
    issue(16, LSL, 16'h0001, 16'd17);
    issue(16, ASR, 16'h8000, 16'd16);
    issue(16, LSL, 16'h0001, 16'd15);
    lat(16, MUL, 16'd300, 16'd200, 16, "w16_mul_lat");
    check_val("w16_mul_300x200", h_result, 16'd60000);
    lat(16, MUL, 16'hFFFF, 16'hFFFF, 16, "w16_mul_ffff");
    lat(16, DIV, 16'd50000, 16'd7, 16, "w16_div_lat");
    lat(16, MOD, 16'd50000, 16'd7, 16, "w16_mod_lat");
    lat(16, DIV, 16'd9, 16'd0, 16, "w16_div0_lat");
    check_val("w16_div0_res_dz", {h_result, h_div_zero}, {16'hFFFF, 1'b1});
    lat(16, ADD, 16'd4, 16'd5, 0, "w16_add_after_div0");
    check_val("w16_div_zero_cleared", h_div_zero, 0);
    for (int i = 0; i < 30; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rop == LSL || rop == LSR || rop == ASR) rb = 16'($urandom_range(0, 18));
      issue(16, rop, ra, rb);
    end
    repeat (30) @(posedge clk);
    #1;
    check_val("sb16_drained", sb16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
